serial_operand_feeder: RTL



---
 rtl/serial_operand_feeder.sv | 93 +++++++++
 1 files changed

// File: rtl/serial_operand_feeder.sv
// Serialises a parallel (a, b, cin) word LSB first for a bit-serial adder: one clear cycle, then WIDTH bit cycles.
// Every output is registered; in_ready is low from acceptance until the word has fully drained, and nothing is queued.
module serial_operand_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             in_ready,
  output logic             adder_clr,
  output logic             a_ser,
  output logic             b_ser,
  output logic             cin_ser,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hold_a, hold_b;
  logic             hold_cin;
  logic             accept;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = CLR;
        end
      end
      CLR: begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
      end
      SHIFT: begin
        if (cnt == LAST) state_nxt = IDLE;
        else             cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each one reflects the state it is entering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_a    <= '0;
      hold_b    <= '0;
      hold_cin  <= 1'b0;
      in_ready  <= 1'b0;
      adder_clr <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      a_ser     <= 1'b0;
      b_ser     <= 1'b0;
      cin_ser   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        hold_a   <= in_a;
        hold_b   <= in_b;
        hold_cin <= in_cin;
      end else if (state_nxt == SHIFT) begin
        // Shift out the bit being presented; cin only ever rides on bit 0.
        hold_a   <= hold_a >> 1;
        hold_b   <= hold_b >> 1;
        hold_cin <= 1'b0;
      end
      in_ready  <= (state_nxt == IDLE);
      adder_clr <= (state_nxt == CLR);
      ser_valid <= (state_nxt == SHIFT);
      ser_last  <= (state_nxt == SHIFT) && (cnt_nxt == LAST);
      a_ser     <= (state_nxt == SHIFT) && hold_a[0];
      b_ser     <= (state_nxt == SHIFT) && hold_b[0];
      cin_ser   <= (state_nxt == SHIFT) && hold_cin;
    end
  end

endmodule
